ram_dp_pipe: RTL and testbench
==============================

// Module: ram_dp_pipe
// PURPOSE
// Parametrised simple-dual-port SRAM model for the mini system: one write port, one read port,
// per-lane write mask, 1- or 2-cycle registered read with valid flag, selectable read-during-write
// policy and optional hardware clear after reset. Successor to the single-port 24-bit RAM; the
// system bus reads and writes it concurrently.
// PARAMETERS
// DATA_W         24  word width in bits; must be a multiple of LANE_W
// LANE_W          8  write-mask granularity in bits; LANES = DATA_W/LANE_W
// ADDR_W         16  address width; DEPTH = 2**ADDR_W words
// RD_LAT          1  read latency in cycles, legal values 1 or 2
// RDW_NEW         0  same-address read+write in one cycle: 0 = old data, 1 = new merged data
// CLEAR_ON_RST    0  1 = zero every word after reset before accepting accesses
// PORTS
// CK      in   1         clock; all state changes on rising edge
// reset   in   1         synchronous, active-high reset
// WE      in   1         write enable
// WA      in   ADDR_W    write address
// WMASK   in   LANES     lane write mask; bit i enables D[i*LANE_W +: LANE_W]
// D       in   DATA_W    write data
// RE      in   1         read enable
// RA      in   ADDR_W    read address
// OE      in   1         output enable; 0 drives Q to all 'z'
// Q       out  DATA_W    read data (registered, gated by OE)
// QV      out  1         read data valid, one-cycle pulse per accepted read
// BUSY    out  1         1 while clear sweep runs; accesses ignored
// BEHAVIOUR
// - Reset (reset=1 at edge): read pipeline flushed; Q register = 0, QV = 0; state = CLEAR with
//   clear pointer 0 if CLEAR_ON_RST=1 (BUSY=1), else READY (BUSY=0). Memory contents untouched.
// - Reset asserted during CLEAR restarts the sweep at address 0; during reads drops in-flight QV.
// - FSM: CLEAR -> writes 0 to word[ptr] each cycle, ptr++; at ptr = DEPTH-1 writes then -> READY.
//   READY stays until reset. Clear lasts exactly DEPTH cycles; BUSY falls the edge after last write.
// - While BUSY: WE and RE ignored (no memory write, no QV). OE still gates Q.
// - Write (READY, WE=1 at edge): for each lane i with WMASK[i]=1, word[WA] lane i <= D lane i;
//   unmasked lanes keep old value. WMASK = 0 -> no change.
// - Read (READY, RE=1 at edge k): RD_LAT=1 -> Q/QV updated at edge k+1 visible after it, i.e.
//   data appears one cycle after request; RD_LAT=2 -> extra output register, valid after edge k+2.
//   Back-to-back reads every cycle: one QV per request, in order, no bubbles.
// - RE=0: QV=0 for the corresponding slot; Q holds its last read value (not cleared).
// - Collision (WE & RE, WA=RA, same edge): RDW_NEW=0 returns pre-write word; RDW_NEW=1 returns
//   word after mask merge. Different addresses: fully independent.
// - Address wrap: addresses are ADDR_W bits, no out-of-range case; clear ptr wraps only in reset.
// - OE is combinational on Q only; it never affects QV, memory or pipeline.
// - Uninitialised words read as X in simulation when CLEAR_ON_RST=0.
// TESTING
// 1 Reset, CLEAR_ON_RST=1, ADDR_W=4: BUSY=1 for exactly 16 cycles, then 0; read all 16 -> Q=0.
// 2 Write A=5 D=24'hA1B2C3 WMASK=3'b111, then WMASK=3'b010 D=24'h00FF00 -> read A=5 Q=24'hA1FFC3.
// 3 RD_LAT=1 and 2: RE pulses at A=1,2,3 back-to-back -> QV high 3 cycles starting 1/2 cycles
//   later, Q in order; OE=0 mid-burst -> Q='z', QV unchanged.
// 4 Collision A=7 holding 24'h111111, write 24'h222222 same cycle: RDW_NEW=0 -> 24'h111111,
//   RDW_NEW=1 -> 24'h222222; next read -> 24'h222222 both.
// 5 WE/RE during BUSY -> no QV, location still 0 after clear; reset at clear ptr=9 -> full sweep restarts.
// 6 reset with read in flight (RD_LAT=2) -> QV stays 0, Q=0 after reset edge.

Source files
------------

// File: rtl/ram_dp_pipe.sv
// ram_dp_pipe: simple dual-port RAM with lane write mask, 1/2-cycle registered read and optional clear sweep
module ram_dp_pipe #(
    parameter int DATA_W       = 24,
    parameter int LANE_W       = 8,
    parameter int ADDR_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int RDW_NEW      = 0,
    parameter int CLEAR_ON_RST = 0
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic                       WE,
    input  logic [ADDR_W-1:0]          WA,
    input  logic [DATA_W/LANE_W-1:0]   WMASK,
    input  logic [DATA_W-1:0]          D,
    input  logic                       RE,
    input  logic [ADDR_W-1:0]          RA,
    input  logic                       OE,
    output logic [DATA_W-1:0]          Q,
    output logic                       QV,
    output logic                       BUSY
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_word, rd_word, q_reg;
    logic              qv_reg, do_wr, do_rd;

    // state register and clear pointer; reset restarts the sweep from address 0
    always_ff @(posedge CK) begin
        if (reset) begin
            state <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // sweep one word per cycle and leave CLEAR once the last address has been zeroed
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == CLEAR) begin
            ptr_nx   = ptr + ADDR_W'(1);
            state_nx = (ptr == '1) ? READY : CLEAR;
        end
    end

    assign do_wr = !reset && (state == READY) && WE;
    assign do_rd = !reset && (state == READY) && RE;

    // lane-masked merge of the incoming data over the currently stored word
    always_comb begin
        wr_word = mem[WA];
        for (int i = 0; i < LANES; i++)
            wr_word[i*LANE_W +: LANE_W] = WMASK[i] ? D[i*LANE_W +: LANE_W] : mem[WA][i*LANE_W +: LANE_W];
    end

    // a same-address write can be forwarded so the read sees the merged word
    assign rd_word = ((RDW_NEW != 0) && do_wr && (WA == RA)) ? wr_word : mem[RA];

    // storage array: the clear sweep owns the array until it finishes
    always_ff @(posedge CK) begin
        if (!reset && state == CLEAR)
            mem[ptr] <= '0;
        else if (do_wr)
            mem[WA] <= wr_word;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] d1;
            logic              v1;
            // first read stage: array output and its slot valid
            always_ff @(posedge CK) begin
                v1 <= reset ? 1'b0 : do_rd;
                if (do_rd)
                    d1 <= rd_word;
            end
            // output register loads only on valid slots so Q keeps the last read value
            always_ff @(posedge CK) begin
                if (reset) begin
                    q_reg  <= '0;
                    qv_reg <= 1'b0;
                end else begin
                    qv_reg <= v1;
                    if (v1)
                        q_reg <= d1;
                end
            end
        end else begin : g_lat1
            // single output register loads only on accepted reads so Q keeps the last read value
            always_ff @(posedge CK) begin
                if (reset) begin
                    q_reg  <= '0;
                    qv_reg <= 1'b0;
                end else begin
                    qv_reg <= do_rd;
                    if (do_rd)
                        q_reg <= rd_word;
                end
            end
        end
    endgenerate

    assign Q    = OE ? q_reg : 'z;
    assign QV   = qv_reg;
    assign BUSY = (state == CLEAR);
endmodule

// File: tb/tb_ram_dp_pipe.sv
// tb_ram_dp_pipe: directed bench driving a 1-cycle/old-data and a 2-cycle/new-data instance in lockstep
module tb_ram_dp_pipe;
    logic        CK = 1'b0;
    logic        reset, WE, RE, OE;
    logic [3:0]  WA, RA;
    logic [2:0]  WMASK;
    logic [23:0] D;
    wire  [23:0] q1, q2;
    wire         qv1, qv2, busy1, busy2;
    logic [23:0] zw = 'z;
    int          n_chk, n_pass, cnt;
    logic        bad;

    always #5 CK = ~CK;

    ram_dp_pipe #(.DATA_W(24), .LANE_W(8), .ADDR_W(4), .RD_LAT(1), .RDW_NEW(0), .CLEAR_ON_RST(1)) u1 (
        .CK(CK), .reset(reset), .WE(WE), .WA(WA), .WMASK(WMASK), .D(D),
        .RE(RE), .RA(RA), .OE(OE), .Q(q1), .QV(qv1), .BUSY(busy1));

    ram_dp_pipe #(.DATA_W(24), .LANE_W(8), .ADDR_W(4), .RD_LAT(2), .RDW_NEW(1), .CLEAR_ON_RST(1)) u2 (
        .CK(CK), .reset(reset), .WE(WE), .WA(WA), .WMASK(WMASK), .D(D),
        .RE(RE), .RA(RA), .OE(OE), .Q(q2), .QV(qv2), .BUSY(busy2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge CK);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [2:0] m, input logic [23:0] d);
        WE = 1'b1; WA = a; WMASK = m; D = d;
        step;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [23:0] e1, input logic [23:0] e2);
        RE = 1'b1; RA = a;
        step;
        RE = 1'b0;
        check("rd_qv1", qv1, 1);
        check("rd_q1", q1, e1);
        check("rd_qv2_early", qv2, 0);
        step;
        check("rd_qv1_drop", qv1, 0);
        check("rd_qv2", qv2, 1);
        check("rd_q2", q2, e2);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b1; WE = 1'b0; RE = 1'b0; OE = 1'b1;
        WA = '0; RA = '0; WMASK = '0; D = '0;
        step;
        check("rst_busy1", busy1, 1);
        check("rst_busy2", busy2, 1);
        check("rst_qv", {qv1, qv2}, 0);
        check("rst_q1", q1, 0);
        check("rst_q2", q2, 0);
        reset = 1'b0;
        repeat (9) step;
        check("mid_busy", busy1, 1);
        reset = 1'b1;
        step;
        reset = 1'b0;
        WE = 1'b1; WA = 4'd3; WMASK = 3'b111; D = 24'hFFFFFF; RE = 1'b1; RA = 4'd3;
        cnt = 0; bad = 1'b0;
        while (busy1 && cnt < 40) begin
            cnt++;
            if (qv1 || qv2) bad = 1'b1;
            step;
        end
        WE = 1'b0; RE = 1'b0;
        check("busy_len", cnt, 16);
        check("busy2_done", busy2, 0);
        check("busy_qv", bad, 0);
        check("busy_qv_last", {qv1, qv2}, 0);
        for (int a = 0; a < 16; a++) rd(4'(a), 24'h0, 24'h0);

        wr(4'd5, 3'b111, 24'hA1B2C3);
        wr(4'd5, 3'b010, 24'h00FF00);
        rd(4'd5, 24'hA1FFC3, 24'hA1FFC3);

        wr(4'd1, 3'b111, 24'h010101);
        wr(4'd2, 3'b111, 24'h020202);
        wr(4'd3, 3'b111, 24'h030303);
        RE = 1'b1; RA = 4'd1;
        step;
        check("b1_qv1", qv1, 1); check("b1_q1", q1, 24'h010101); check("b1_qv2", qv2, 0);
        RA = 4'd2;
        step;
        check("b2_q1", q1, 24'h020202); check("b2_qv2", qv2, 1); check("b2_q2", q2, 24'h010101);
        RA = 4'd3; OE = 1'b0;
        #1;
        check("oe_q1", q1, zw); check("oe_q2", q2, zw); check("oe_qv", {qv1, qv2}, 2'b11);
        OE = 1'b1;
        step;
        check("b3_qv1", qv1, 1); check("b3_q1", q1, 24'h030303); check("b3_q2", q2, 24'h020202);
        RE = 1'b0;
        step;
        check("b4_qv1", qv1, 0); check("b4_q1_hold", q1, 24'h030303);
        check("b4_qv2", qv2, 1); check("b4_q2", q2, 24'h030303);
        step;
        check("b5_qv2", qv2, 0); check("b5_q2_hold", q2, 24'h030303);

        wr(4'd7, 3'b111, 24'h111111);
        WE = 1'b1; WA = 4'd7; WMASK = 3'b111; D = 24'h222222; RE = 1'b1; RA = 4'd7;
        step;
        WE = 1'b0; RE = 1'b0;
        check("col_q1_old", q1, 24'h111111);
        step;
        check("col_q2_new", q2, 24'h222222);
        rd(4'd7, 24'h222222, 24'h222222);

        WE = 1'b1; WA = 4'd8; WMASK = 3'b111; D = 24'h123456; RE = 1'b1; RA = 4'd5;
        step;
        WE = 1'b0; RE = 1'b0;
        check("ind_q1", q1, 24'hA1FFC3);
        step;
        check("ind_q2", q2, 24'hA1FFC3);
        rd(4'd8, 24'h123456, 24'h123456);

        RE = 1'b1; RA = 4'd5;
        step;
        RE = 1'b0; reset = 1'b1;
        step;
        reset = 1'b0;
        check("rrst_qv", {qv1, qv2}, 0);
        check("rrst_q1", q1, 0);
        check("rrst_q2", q2, 0);
        step;
        check("rrst_qv2_drop", qv2, 0);
        cnt = 0;
        while (busy1 && cnt < 40) begin
            cnt++;
            step;
        end
        check("rrst_busy_len", cnt, 15);
        rd(4'd5, 24'h0, 24'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
